bcd_to_unsigned: RTL and testbench

- Sequential packed-BCD to unsigned-binary converter, using reverse double dabble (shift right, then subtract 3 from each digit ≥ 8).
- It is the inverse of the calculator's unsigned-to-BCD display path. It converts decimal digit entry from switches or registers into binary operands for the ALU.
- Handshake is trigger/idle/done, matching the team's existing converter style.

---
 rtl/bcd_to_unsigned.sv | 144 ++++++++++++++
 tb/tb_bcd_to_unsigned.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_unsigned.sv
// Packed-BCD to unsigned binary converter. Uses reverse double dabble, one bit per clock.
// Handshake is trigger / idle / done; results are held until the next completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for trigger; a nibble > 9 skips straight to S_DONE
// S_CONVERT | one shift/correct iteration per clock, OUT_W iterations
// S_DONE  | publish result/error; done/bin_out/error update on exit
module bcd_to_unsigned #(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  idle,
  output logic                  done,
  output logic                  error,
  output logic [OUT_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [OUT_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_pend_q, err_pend_d;
  logic               idle_q, idle_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [OUT_W-1:0]   bin_out_q, bin_out_d;

  logic               bad_digit;
  logic [BCD_W+OUT_W-1:0] shifted;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign shifted = {bcd_q, bin_q} >> 1;

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    idle_d     = idle_q;
    done_d     = 1'b0;
    error_d    = error_q;
    bin_out_d  = bin_out_q;

    case (state_q)
      S_IDLE: begin
        idle_d = 1'b1;
        // idle_q stays low for the cycle that shows done, so acceptance keys off it
        if (trigger && idle_q) begin
          idle_d = 1'b0;
          if (bad_digit) begin
            err_pend_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            bcd_d      = bcd_in;
            bin_d      = '0;
            cnt_d      = '0;
            err_pend_d = 1'b0;
            state_d    = S_CONVERT;
          end
        end
      end

      S_CONVERT: begin
        idle_d = 1'b0;
        bin_d  = shifted[OUT_W-1:0];
        bcd_d  = shifted[BCD_W+OUT_W-1:OUT_W];
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_d[4*i +: 4] >= 4'd8) bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_W - 1)) state_d = S_DONE;
      end

      S_DONE: begin
        idle_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (err_pend_q) begin
          bin_out_d = '0;
          error_d   = 1'b1;
        end else begin
          bin_out_d = bin_q;
          error_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        idle_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      bin_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      idle_q     <= idle_d;
      done_q     <= done_d;
      error_q    <= error_d;
      bin_out_q  <= bin_out_d;
    end
  end

  assign idle    = idle_q;
  assign done    = done_q;
  assign error   = error_q;
  assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Randomized scoreboard bench for bcd_to_unsigned.
// The driver pushes decimal-arithmetic expectations; a negedge monitor checks every done pulse.
module tb_bcd_to_unsigned;

  localparam int DIGITS = 8;
  localparam int OUT_W  = 27;

  logic               clk = 1'b0;
  logic               reset;
  logic               trigger;
  logic [4*DIGITS-1:0] bcd_in;
  logic               idle, done, error;
  logic [OUT_W-1:0]   bin_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic             err;
    logic [OUT_W-1:0] val;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  bcd_to_unsigned #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd_in  (bcd_in),
    .idle    (idle),
    .done    (done),
    .error   (error),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain decimal arithmetic on the digit values.
  function automatic bit ref_bad(input logic [4*DIGITS-1:0] b);
    bit r = 0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 9) r = 1;
    return r;
  endfunction

  function automatic longint ref_val(input logic [4*DIGITS-1:0] b);
    longint v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
    return v;
  endfunction

  // Stand-in for the unsigned-to-BCD display path.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned n);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [4*DIGITS-1:0] b, input int acc);
    exp_t e;
    e.err = ref_bad(b);
    e.val = e.err ? '0 : OUT_W'(ref_val(b));
    e.due = acc + (e.err ? 1 : OUT_W + 1);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("bin_out", longint'(bin_out), longint'(mon_e.val));
        chk("error", longint'(error), longint'(mon_e.err));
        chk("latency", longint'(cyc), longint'(mon_e.due));
        chk("idle_during_done", longint'(idle), 0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Issue one request; sb entry pushed on the accepting negedge.
  task automatic issue(input logic [4*DIGITS-1:0] v);
    wait_idle();
    trigger = 1'b1;
    bcd_in  = v;
    @(negedge clk);
    sb.push_back(make_exp(v, cyc));
    trigger = 1'b0;
    bcd_in  = $urandom;
  endtask

  task automatic run(input logic [4*DIGITS-1:0] v);
    issue(v);
    wait_done();
    @(negedge clk);
    chk("idle_after_done", longint'(idle), 1);
    chk("done_one_cycle", longint'(done), 0);
  endtask

  initial begin
    logic [4*DIGITS-1:0] v;
    int unsigned n;

    reset   = 1'b1;
    trigger = 1'b0;
    bcd_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_idle", longint'(idle), 1);
    chk("rst_done", longint'(done), 0);
    chk("rst_error", longint'(error), 0);
    chk("rst_bin_out", longint'(bin_out), 0);
    reset = 1'b0;
    @(negedge clk);

    run(32'h0001_2345);
    run(32'h9999_9999);
    run(32'h0000_0000);
    run(32'h0000_A123);
    run(32'h0000_0042);
    run(32'hF000_0000);
    run(32'h0000_0001);

    // Retrigger mid-conversion must be ignored.
    issue(32'h0000_0100);
    repeat (8) @(negedge clk);
    trigger = 1'b1;
    bcd_in  = 32'h0000_0999;
    @(negedge clk);
    trigger = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    chk("no_extra_done", longint'(sb.size()), 0);
    chk("held_bin_out", longint'(bin_out), 100);

    // Reset during conversion aborts without done.
    wait_idle();
    trigger = 1'b1;
    bcd_in  = 32'h0055_5555;
    @(negedge clk);
    trigger = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_idle", longint'(idle), 1);
    chk("abort_done", longint'(done), 0);
    chk("abort_error", longint'(error), 0);
    chk("abort_bin_out", longint'(bin_out), 0);
    repeat (40) @(negedge clk);
    run(32'h0000_0777);

    // Random 8-digit entries, some with an illegal nibble.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      run(v);
    end

    // Round trip through the binary-to-BCD model.
    for (int k = 0; k < 1000; k++) begin
      n = $urandom_range(0, 65535);
      issue(to_bcd(n));
      wait_done();
      chk("round_trip", longint'(bin_out), longint'(n));
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
